// File: rtl/ram_arbiter.sv
// Round-robin arbiter between instruction-fetch and data ports in front of the SRAM driver.
// Sequences enable/enable_read/enable_write and returns data with a one-cycle ack.
module ram_arbiter #(
  parameter int READ_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ireq,
  input  logic [20:0] iaddr,
  output logic [31:0] irdata,
  output logic        iack,
  input  logic        dreq,
  input  logic        dwe,
  input  logic [20:0] daddr,
  input  logic [31:0] dwdata,
  output logic [31:0] drdata,
  output logic        dack,
  output logic        ram_enable,
  output logic        ram_enable_read,
  output logic        ram_enable_write,
  output logic [20:0] ram_addr,
  output logic [31:0] ram_data_in,
  input  logic [31:0] ram_data_out,
  input  logic        ram_read_ready,
  input  logic        ram_write_finished
);
  typedef enum logic [2:0] {
    S_DRAIN, S_IDLE, S_RD_ISSUE, S_RD_WAIT, S_WR_ISSUE, S_WR_WAIT, S_ACK
  } state_t;

  localparam logic [3:0] LP_LAST_RDY = 4'(READ_WAIT - 1);

  state_t      r_state, w_state;
  logic [3:0]  r_cnt, w_cnt;
  logic        r_last_d, w_last_d;
  logic        w_gnt_d;
  logic [31:0] r_irdata, w_irdata, r_drdata, w_drdata, r_wdat, w_wdat;
  logic [20:0] r_addr, w_addr;
  logic        r_iack, w_iack, r_dack, w_dack;
  logic        r_en, w_en, r_en_rd, w_en_rd, r_en_wr, w_en_wr;

  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_last_d = r_last_d;
    w_gnt_d  = 1'b0;
    w_irdata = r_irdata;
    w_drdata = r_drdata;
    w_wdat   = r_wdat;
    w_addr   = r_addr;
    w_iack   = 1'b0;
    w_dack   = 1'b0;
    w_en     = r_en;
    w_en_rd  = r_en_rd;
    w_en_wr  = 1'b0;
    case (r_state)
      S_DRAIN: begin
        w_en    = 1'b0;
        w_en_rd = 1'b0;
        if (r_cnt == 4'd2) begin
          w_state = S_IDLE;
          w_cnt   = 4'd0;
        end else begin
          w_cnt = r_cnt + 4'd1;
        end
      end
      S_IDLE: begin
        // r_last_d doubles as the owner of the transaction in flight
        w_gnt_d = dreq && (!ireq || !r_last_d);
        if (ireq || dreq) begin
          w_last_d = w_gnt_d;
          w_cnt    = 4'd0;
          w_en     = 1'b1;
          w_addr   = w_gnt_d ? daddr : iaddr;
          if (w_gnt_d && dwe) begin
            w_wdat  = dwdata;
            w_en_wr = 1'b1;
            w_state = S_WR_ISSUE;
          end else begin
            w_en_rd = 1'b1;
            w_state = S_RD_ISSUE;
          end
        end
      end
      S_RD_ISSUE, S_RD_WAIT: begin
        w_state = S_RD_WAIT;
        if (ram_read_ready) begin
          if (r_cnt == LP_LAST_RDY) begin
            if (r_last_d) begin
              w_drdata = ram_data_out;
              w_dack   = 1'b1;
            end else begin
              w_irdata = ram_data_out;
              w_iack   = 1'b1;
            end
            w_en    = 1'b0;
            w_en_rd = 1'b0;
            w_state = S_ACK;
          end else begin
            w_cnt = r_cnt + 4'd1;
          end
        end
      end
      S_WR_ISSUE: w_state = S_WR_WAIT;
      S_WR_WAIT: begin
        if (ram_write_finished) begin
          w_en    = 1'b0;
          w_dack  = 1'b1;
          w_state = S_ACK;
        end
      end
      S_ACK:   w_state = S_IDLE;
      default: w_state = S_DRAIN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_DRAIN;
      r_cnt    <= 4'd0;
      r_last_d <= 1'b0;
      r_irdata <= '0;
      r_drdata <= '0;
      r_wdat   <= '0;
      r_addr   <= '0;
      r_iack   <= 1'b0;
      r_dack   <= 1'b0;
      r_en     <= 1'b0;
      r_en_rd  <= 1'b0;
      r_en_wr  <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_last_d <= w_last_d;
      r_irdata <= w_irdata;
      r_drdata <= w_drdata;
      r_wdat   <= w_wdat;
      r_addr   <= w_addr;
      r_iack   <= w_iack;
      r_dack   <= w_dack;
      r_en     <= w_en;
      r_en_rd  <= w_en_rd;
      r_en_wr  <= w_en_wr;
    end
  end

  assign irdata           = r_irdata;
  assign iack             = r_iack;
  assign drdata           = r_drdata;
  assign dack             = r_dack;
  assign ram_enable       = r_en;
  assign ram_enable_read  = r_en_rd;
  assign ram_enable_write = r_en_wr;
  assign ram_addr         = r_addr;
  assign ram_data_in      = r_wdat;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: SRAM driver models, a cycle-schedule reference model, and directed scenarios.
module tb_ram_arbiter;
  localparam int RW = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_bad = 0;

  logic        ireq = 1'b0, dreq = 1'b0, dwe = 1'b0;
  logic [20:0] iaddr = '0, daddr = '0;
  logic [31:0] dwdata = '0;
  logic [31:0] irdata, drdata, ram_data_in;
  logic        iack, dack, ram_enable, ram_enable_read, ram_enable_write;
  logic [20:0] ram_addr;
  logic [31:0] ram_data_out = '0;
  logic        ram_read_ready = 1'b0, ram_write_finished = 1'b0;

  logic        ireq3 = 1'b0;
  logic [20:0] iaddr3 = '0;
  logic [31:0] irdata3, drdata3, din3;
  logic        iack3, dack3, en3, enr3, enw3;
  logic [20:0] addr3;
  logic [31:0] dout3 = '0;
  logic        rrdy3 = 1'b0;

  ram_arbiter #(.READ_WAIT(RW)) u_dut (
    .clk(clk), .rst(rst),
    .ireq(ireq), .iaddr(iaddr), .irdata(irdata), .iack(iack),
    .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata), .drdata(drdata), .dack(dack),
    .ram_enable(ram_enable), .ram_enable_read(ram_enable_read), .ram_enable_write(ram_enable_write),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
    .ram_read_ready(ram_read_ready), .ram_write_finished(ram_write_finished)
  );

  ram_arbiter #(.READ_WAIT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .ireq(ireq3), .iaddr(iaddr3), .irdata(irdata3), .iack(iack3),
    .dreq(1'b0), .dwe(1'b0), .daddr(21'h0), .dwdata(32'h0), .drdata(drdata3), .dack(dack3),
    .ram_enable(en3), .ram_enable_read(enr3), .ram_enable_write(enw3),
    .ram_addr(addr3), .ram_data_in(din3), .ram_data_out(dout3),
    .ram_read_ready(rrdy3), .ram_write_finished(1'b0)
  );

  // Power-on SRAM contents
  function automatic logic [31:0] init_val(input logic [20:0] a);
    return (a == 21'h000010) ? 32'hDEADBEEF : {11'h5A5, a};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // Driver model: read data one cycle after enable_read, write_finished three cycles after the write command
  logic [31:0] drv_mem [int];
  int wcnt = 0;
  always @(posedge clk) begin
    ram_read_ready <= ram_enable && ram_enable_read;
    ram_data_out   <= drv_mem.exists(int'(ram_addr)) ? drv_mem[int'(ram_addr)] : init_val(ram_addr);
    ram_write_finished <= (wcnt == 1);
    if (ram_enable && ram_enable_write) begin
      drv_mem[int'(ram_addr)] = ram_data_in;
      wcnt <= 2;
    end else if (wcnt != 0) begin
      wcnt <= wcnt - 1;
    end
  end

  always @(posedge clk) begin
    rrdy3 <= en3 && enr3;
    dout3 <= init_val(addr3);
  end

  // Reference: each grant books a fixed window [g+1, ack-1] of command activity and an ack cycle
  logic [31:0] ref_mem [int];
  bit          m_busy = 1'b0, m_rd = 1'b0, m_d = 1'b0, m_last = 1'b0, m_win = 1'b0, m_gd = 1'b0;
  int          m_g = 0, m_a = 0, m_free = 0;
  logic [20:0] m_addr = '0;
  logic [31:0] m_wdat = '0, e_ir = '0, e_dr = '0, m_val = '0;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_en", {31'b0, ram_enable}, 32'd0);
      chk("rst_en_rd", {31'b0, ram_enable_read}, 32'd0);
      chk("rst_en_wr", {31'b0, ram_enable_write}, 32'd0);
      chk("rst_acks", {30'b0, iack, dack}, 32'd0);
      chk("rst_rdata", irdata | drdata, 32'd0);
      m_busy = 1'b0;
      m_last = 1'b0;
      m_free = cyc + 4;
      e_ir   = '0;
      e_dr   = '0;
    end else begin
      if (m_busy && cyc == m_a && m_rd) begin
        m_val = ref_mem.exists(int'(m_addr)) ? ref_mem[int'(m_addr)] : init_val(m_addr);
        if (m_d) e_dr = m_val;
        else     e_ir = m_val;
      end
      m_win = m_busy && cyc > m_g && cyc < m_a;
      chk("m_en", {31'b0, ram_enable}, {31'b0, m_win});
      chk("m_en_rd", {31'b0, ram_enable_read}, {31'b0, m_win && m_rd});
      chk("m_en_wr", {31'b0, ram_enable_write}, {31'b0, m_busy && !m_rd && cyc == m_g + 1});
      chk("m_iack", {31'b0, iack}, {31'b0, m_busy && cyc == m_a && !m_d});
      chk("m_dack", {31'b0, dack}, {31'b0, m_busy && cyc == m_a && m_d});
      chk("m_irdata", irdata, e_ir);
      chk("m_drdata", drdata, e_dr);
      if (m_win) chk("m_addr", {11'b0, ram_addr}, {11'b0, m_addr});
      if (m_busy && !m_rd && cyc == m_g + 1) chk("m_wdata", ram_data_in, m_wdat);
      if (m_busy && cyc == m_a) begin
        m_busy = 1'b0;
        m_free = cyc + 1;
      end
      if (!m_busy && cyc >= m_free && (ireq || dreq)) begin
        m_gd   = dreq && (!ireq || !m_last);
        m_last = m_gd;
        m_d    = m_gd;
        m_rd   = !(m_gd && dwe);
        m_addr = m_gd ? daddr : iaddr;
        m_wdat = dwdata;
        m_g    = cyc;
        m_a    = m_rd ? cyc + 2 + RW : cyc + 5;
        m_busy = 1'b1;
        if (!m_rd) ref_mem[int'(daddr)] = dwdata;
      end
    end
  end

  task automatic wait_ack(input bit d, output int ta, output int nwr, output int nen);
    bit got;
    got = 1'b0;
    ta  = 0;
    nwr = 0;
    nen = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (ram_enable_write) nwr++;
      if (ram_enable) nen++;
      if (d ? dack : iack) begin
        got = 1'b1;
        ta  = cyc;
      end
    end
    chk("ack_seen", {31'b0, got}, 32'd1);
  endtask

  initial begin
    int t0, ta, ta2, nwr, nen, c0, prev;
    bit got;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Instruction read after reset
    t0 = cyc; ireq = 1'b1; iaddr = 21'h000010;
    @(negedge clk); chk("t1_en_rd_c0", {31'b0, ram_enable_read}, 32'd0);
    @(negedge clk); chk("t1_en_rd_c1", {31'b0, ram_enable_read}, 32'd1);
    wait_ack(1'b0, ta, nwr, nen);
    chk("t1_lat", ta - t0, 32'd3);
    chk("t1_irdata", irdata, 32'hDEADBEEF);
    @(posedge clk); #1 ireq = 1'b0;

    // Data write
    t0 = cyc; dreq = 1'b1; dwe = 1'b1; daddr = 21'h100004; dwdata = 32'h12345678;
    wait_ack(1'b1, ta, nwr, nen);
    chk("t2_lat", ta - t0, 32'd5);
    chk("t2_wr_pulses", nwr, 32'd1);
    chk("t2_en_cycles", nen, 32'd4);
    @(posedge clk); #1 dreq = 1'b0;

    // Read back the written word
    t0 = cyc; dreq = 1'b1; dwe = 1'b0; daddr = 21'h100004; dwdata = 32'h0;
    wait_ack(1'b1, ta, nwr, nen);
    chk("t2_rb_lat", ta - t0, 32'd3);
    chk("t2_rb_data", drdata, 32'h12345678);
    @(posedge clk); #1 dreq = 1'b0;

    // Reset while waiting for write_finished
    t0 = cyc; dreq = 1'b1; dwe = 1'b1; daddr = 21'h000200; dwdata = 32'hA5A5A5A5;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1; dreq = 1'b0; dwe = 1'b0;
    #1 chk("t5_en_async", {31'b0, ram_enable}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Contention straight out of reset: data first, then alternating
    c0 = cyc; prev = cyc;
    ireq = 1'b1; iaddr = 21'h000200; dreq = 1'b1; daddr = 21'h000010;
    for (int k = 0; k < 6; k++) begin
      got = 1'b0;
      for (int j = 0; j < 40 && !got; j++) begin
        @(negedge clk);
        if (iack || dack) got = 1'b1;
      end
      chk("cont_ack_seen", {31'b0, got}, 32'd1);
      chk("cont_order", {31'b0, dack}, {31'b0, (k % 2) == 0});
      if (k == 0) chk("cont_first_cycle", cyc - c0, 32'd6);
      else        chk("cont_gap", cyc - prev, 32'd4);
      if (k == 0) chk("cont_drdata", drdata, 32'hDEADBEEF);
      if (k == 1) chk("cont_irdata", irdata, 32'hA5A5A5A5);
      prev = cyc;
    end
    @(posedge clk); #1 ireq = 1'b0; dreq = 1'b0;
    @(posedge clk); #1;

    // Back-to-back data reads with address change after grant
    dreq = 1'b1; dwe = 1'b0; daddr = 21'h000010;
    wait_ack(1'b1, ta, nwr, nen);
    chk("b2b_first_data", drdata, 32'hDEADBEEF);
    @(posedge clk); #1 daddr = 21'h100004;
    @(negedge clk);
    chk("b2b_ack1_single", {31'b0, dack}, 32'd0);
    chk("b2b_gap_idle", {31'b0, ram_enable}, 32'd0);
    @(posedge clk); #1 daddr = 21'h1FFFFF;
    @(negedge clk);
    chk("b2b_start", {31'b0, ram_enable}, 32'd1);
    chk("b2b_addr", {11'b0, ram_addr}, {11'b0, 21'h100004});
    wait_ack(1'b1, ta2, nwr, nen);
    chk("b2b_ack_gap", ta2 - ta, 32'd4);
    chk("b2b_second_data", drdata, 32'h12345678);
    @(posedge clk); #1 dreq = 1'b0;
    @(negedge clk); chk("b2b_ack2_single", {31'b0, dack}, 32'd0);

    // READ_WAIT=3 instance
    @(posedge clk); #1;
    t0 = cyc; ireq3 = 1'b1; iaddr3 = 21'h0000FF;
    @(negedge clk); chk("rw3_en_rd_c0", {31'b0, enr3}, 32'd0);
    @(negedge clk); chk("rw3_en_rd_c1", {31'b0, enr3}, 32'd1);
    repeat (3) @(negedge clk);
    chk("rw3_no_ack_c4", {31'b0, iack3}, 32'd0);
    chk("rw3_en_rd_c4", {31'b0, enr3}, 32'd1);
    @(negedge clk);
    chk("rw3_ack_c5", {31'b0, iack3}, 32'd1);
    chk("rw3_data", irdata3, init_val(21'h0000FF));
    chk("rw3_en_rd_c5", {31'b0, enr3}, 32'd0);
    chk("rw3_cycle", cyc - t0, 32'd5);
    @(posedge clk); #1 ireq3 = 1'b0;
    @(negedge clk); chk("rw3_ack_single", {31'b0, iack3}, 32'd0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

endmodule
